rgb565_window_stream: RTL



---
 rtl/rgb565_window_stream_if.sv | 24 ++
 rtl/rgb565_window_stream.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rgb565_window_stream_if.sv
// Pixel input bus and RGB888 output stream of rgb565_window_stream.
// The master side is the camera receiver plus the stream consumer; the slave side is the window block.
interface rgb565_window_stream_if;
    logic [15:0] pixel_i;
    logic        pixel_valid_i;
    logic        vstart_i;
    logic        hstart_i;
    logic [23:0] out_data_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        out_sof_o;
    logic        out_eol_o;
    logic        overflow_o;

    modport master (
        output pixel_i, pixel_valid_i, vstart_i, hstart_i, out_ready_i,
        input  out_data_o, out_valid_o, out_sof_o, out_eol_o, overflow_o
    );

    modport slave (
        input  pixel_i, pixel_valid_i, vstart_i, hstart_i, out_ready_i,
        output out_data_o, out_valid_o, out_sof_o, out_eol_o, overflow_o
    );
endinterface

// File: rtl/rgb565_window_stream.sv
// Crops a window out of an RGB565 pixel stream, expands kept pixels to RGB888 and queues them in a FWFT FIFO.
// Define RGB565_WINDOW_GRAY_EN to output {Y,Y,Y} luma instead of RGB888.
module rgb565_window_stream #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int CROP_X0    = 0,
    parameter int CROP_Y0    = 0,
    parameter int CROP_W     = 640,
    parameter int CROP_H     = 480,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   pclk_i,
    input  logic                   rst_i,
    rgb565_window_stream_if.slave  bus
);

    localparam int XW = $clog2(IMG_W + 1);
    localparam int YW = $clog2(IMG_H + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [XW-1:0] X_SAT   = XW'(IMG_W);
    localparam logic [XW-1:0] X_FIRST = XW'(CROP_X0);
    localparam logic [XW-1:0] X_LAST  = XW'(CROP_X0 + CROP_W - 1);
    localparam logic [XW-1:0] X_SPAN  = XW'(CROP_W);
    localparam logic [YW-1:0] Y_MAX   = YW'(IMG_H - 1);
    localparam logic [YW-1:0] Y_FIRST = YW'(CROP_Y0);
    localparam logic [YW-1:0] Y_SPAN  = YW'(CROP_H);
    localparam logic [CW-1:0] C_FULL  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [PW-1:0] P_ONE   = PW'(1);

    typedef enum logic {
        ST_UNSYNCED,
        ST_SYNCED
    } sync_state_t;

    sync_state_t r_state;
    sync_state_t w_stateNext;
    logic        w_accept;

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_yOver;
    logic [XW-1:0] w_xNext;
    logic [YW-1:0] w_yNext;
    logic          w_yOverNext;
    logic [XW-1:0] w_xOff;
    logic [YW-1:0] w_yOff;
    logic          w_keep;

    logic          r_s1Keep;
    logic          r_s1Vstart;
    logic [15:0]   r_s1Pix;

    logic [7:0]    w_r8;
    logic [7:0]    w_g8;
    logic [7:0]    w_b8;
    logic [23:0]   w_pixOut;

    logic          r_s2Keep;
    logic          r_s2Sof;
    logic          r_s2Eol;
    logic [23:0]   r_s2Data;

    logic [25:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic [25:0]   w_head;
    logic          w_valid;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          r_overflow;

    // Nothing is trusted until the first start-of-frame strobe has been seen.
    always_ff @(posedge pclk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_UNSYNCED;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_UNSYNCED: begin
                if (bus.pixel_valid_i && bus.vstart_i) begin
                    w_accept    = 1'b1;
                    w_stateNext = ST_SYNCED;
                end
            end
            ST_SYNCED: begin
                w_accept = bus.pixel_valid_i;
            end
            default: begin
                w_stateNext = ST_UNSYNCED;
            end
        endcase
    end

    always_comb begin
        w_xNext     = r_x;
        w_yNext     = r_y;
        w_yOverNext = r_yOver;
        if (bus.vstart_i) begin
            w_xNext     = '0;
            w_yNext     = '0;
            w_yOverNext = 1'b0;
        end else if (bus.hstart_i) begin
            w_xNext = '0;
            if (r_y == Y_MAX) begin
                w_yOverNext = 1'b1;
            end else begin
                w_yNext = r_y + 1'b1;
            end
        end else if (r_x != X_SAT) begin
            w_xNext = r_x + 1'b1;
        end
    end

    // Offsets wrap to large values below the window origin, so one compare checks both bounds.
    assign w_xOff = w_xNext - X_FIRST;
    assign w_yOff = w_yNext - Y_FIRST;
    assign w_keep = (w_xOff < X_SPAN) && (w_yOff < Y_SPAN) &&
                    (w_xNext != X_SAT) && !w_yOverNext;

    always_ff @(posedge pclk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_x        <= '0;
            r_y        <= '0;
            r_yOver    <= 1'b0;
            r_s1Keep   <= 1'b0;
            r_s1Vstart <= 1'b0;
            r_s1Pix    <= '0;
        end else begin
            r_s1Keep   <= w_accept && w_keep;
            r_s1Vstart <= w_accept && bus.vstart_i;
            if (w_accept) begin
                r_x     <= w_xNext;
                r_y     <= w_yNext;
                r_yOver <= w_yOverNext;
                r_s1Pix <= bus.pixel_i;
            end
        end
    end

    assign w_r8 = {r_s1Pix[15:11], r_s1Pix[15:13]};
    assign w_g8 = {r_s1Pix[10:5],  r_s1Pix[10:9]};
    assign w_b8 = {r_s1Pix[4:0],   r_s1Pix[4:2]};

`ifdef RGB565_WINDOW_GRAY_EN
    logic [15:0] w_luma;
    logic [7:0]  w_gray;
    assign w_luma   = 16'd77 * {8'd0, w_r8} + 16'd150 * {8'd0, w_g8} + 16'd29 * {8'd0, w_b8};
    assign w_gray   = 8'(w_luma >> 8);
    assign w_pixOut = {w_gray, w_gray, w_gray};
`else
    assign w_pixOut = {w_r8, w_g8, w_b8};
`endif

    // Stage 1 coordinates stay in r_x/r_y until the next accepted strobe, which lands on this same edge.
    always_ff @(posedge pclk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_s2Keep <= 1'b0;
            r_s2Sof  <= 1'b0;
            r_s2Eol  <= 1'b0;
            r_s2Data <= '0;
        end else begin
            r_s2Keep <= r_s1Keep;
            r_s2Sof  <= (r_x == X_FIRST) && (r_y == Y_FIRST);
            r_s2Eol  <= (r_x == X_LAST);
            r_s2Data <= w_pixOut;
        end
    end

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && bus.out_ready_i;
    assign w_push  = r_s2Keep && ((r_count != C_FULL) || w_pop);
    assign w_drop  = r_s2Keep && !w_push;
    assign w_head  = r_mem[r_rdPtr];

    always_ff @(posedge pclk_i) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {r_s2Sof, r_s2Eol, r_s2Data};
        end
    end

    always_ff @(posedge pclk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + P_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + P_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // A drop on the same edge as the frame-start clear must leave the flag set.
    always_ff @(posedge pclk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (r_s1Vstart) begin
            r_overflow <= 1'b0;
        end
    end

    assign bus.out_valid_o = w_valid;
    assign bus.out_data_o  = w_valid ? w_head[23:0] : 24'd0;
    assign bus.out_sof_o   = w_valid && w_head[25];
    assign bus.out_eol_o   = w_valid && w_head[24];
    assign bus.overflow_o  = r_overflow;

endmodule
